// File: rtl/bcd_arbiter_pkg.sv
// Shared types and constants for the round-robin BCD conversion arbiter.
// Optional build macro: BCD_ARB_OVF_CLAMP_EN (clamp out-of-range values).
package bcd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam int          SHIFT_CYCLES = 20;
    localparam int          BCD_DIGITS   = 6;
    localparam logic [19:0] MAX_VAL      = 20'd999999;

    // Add 3 to every digit above 4 before the next left shift.
    function automatic logic [23:0] add3_digits(input logic [23:0] d);
        logic [23:0] r;
        r = d;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (d[4*i +: 4] > 4'd4)
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_dabble_core.sv
// Double-dabble datapath: 20-bit binary shifted into six BCD digits.
// Sequencing (load / 20 shift strobes) is owned by the caller.
module bcd_dabble_core
    import bcd_arbiter_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        load,
    input  logic        shift_en,
    input  logic [19:0] bin,
    output logic [23:0] bcd
);

    logic [19:0] sh_q;
    logic [23:0] dig_q;
    logic [23:0] adj;

    assign adj = add3_digits(dig_q);
    assign bcd = dig_q;

    // Bits carried out of the top digit are dropped, giving value mod 10^6.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            dig_q <= '0;
            sh_q  <= '0;
        end else if (load) begin
            dig_q <= '0;
            sh_q  <= bin;
        end else if (shift_en) begin
            {dig_q, sh_q} <= {adj, sh_q} << 1;
        end
    end

endmodule

// File: rtl/bcd_arbiter.sv
// Round-robin arbiter feeding one shared binary-to-BCD converter.
// Optional build macro: BCD_ARB_OVF_CLAMP_EN (clamp values above 999999).
module bcd_arbiter
    import bcd_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int GW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*20-1:0] data,
    output logic [N_REQ-1:0]    ack,
    output logic [23:0]         bcd_out,
    output logic [GW-1:0]       grant_idx,
    output logic                busy,
    output logic                ovf
);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [GW-1:0] last_q, cur_q, grant_q, win_idx;
    logic        win_found;
    logic [19:0] sel_data, load_val, val_q;
    logic        sel_ovf, ovf_cur_q, ovf_q;
    logic [23:0] bcd_q, core_bcd;

    // Search starts one past the last grant.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!win_found && req[(int'(last_q) + k) % N_REQ]) begin
                win_found = 1'b1;
                win_idx   = GW'((int'(last_q) + k) % N_REQ);
            end
        end
    end

    assign sel_data = data[int'(win_idx)*20 +: 20];
    assign sel_ovf  = sel_data > MAX_VAL;

`ifdef BCD_ARB_OVF_CLAMP_EN
    assign load_val = sel_ovf ? MAX_VAL : sel_data;
`else
    assign load_val = sel_data;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (win_found) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == 5'(SHIFT_CYCLES - 1)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        for (int i = 0; i < N_REQ; i++)
            ack[i] = (state_q == ST_DONE) && (cur_q == GW'(i));
        bcd_out   = (state_q == ST_DONE) ? core_bcd  : bcd_q;
        grant_idx = (state_q == ST_DONE) ? cur_q     : grant_q;
        ovf       = (state_q == ST_DONE) ? ovf_cur_q : ovf_q;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q     <= '0;
            last_q    <= GW'(N_REQ - 1);
            cur_q     <= '0;
            val_q     <= '0;
            ovf_cur_q <= 1'b0;
            bcd_q     <= '0;
            grant_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && win_found) begin
                cur_q     <= win_idx;
                last_q    <= win_idx;
                val_q     <= load_val;
                ovf_cur_q <= sel_ovf;
            end
            if (state_q == ST_LOAD)
                cnt_q <= '0;
            else if (state_q == ST_SHIFT)
                cnt_q <= cnt_q + 5'd1;
            // Results are published here and held until the next DONE.
            if (state_q == ST_DONE) begin
                bcd_q   <= core_bcd;
                grant_q <= cur_q;
                ovf_q   <= ovf_cur_q;
            end
        end
    end

    bcd_dabble_core u_core (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .load     (state_q == ST_LOAD),
        .shift_en (state_q == ST_SHIFT),
        .bin      (val_q),
        .bcd      (core_bcd)
    );

endmodule

// File: tb/tb_bcd_arbiter.sv
// Directed bench for bcd_arbiter: latency, round-robin order, boundaries,
// overflow handling and mid-conversion reset.
module tb_bcd_arbiter;

    localparam int N = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic [N-1:0]  req;
    logic [N*20-1:0] data;
    logic [N-1:0]  ack;
    logic [23:0]   bcd_out;
    logic [1:0]    grant_idx;
    logic          busy;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    bcd_arbiter #(.N_REQ(N)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req       (req),
        .data      (data),
        .ack       (ack),
        .bcd_out   (bcd_out),
        .grant_idx (grant_idx),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [19:0] v);
        data[20*i +: 20] = v;
    endtask

    // Counts rising edges (sampled #1 after) until ack rises, bounded.
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(posedge sys_clk);
            #1;
            n++;
        end while (ack == '0 && n < 200);
    endtask

    task automatic serve(input string tag, input int idx,
                         input logic [23:0] exp_bcd, input logic exp_ovf,
                         input int exp_lat);
        int n;
        logic [N-1:0] exp_ack;
        exp_ack = '0;
        exp_ack[idx] = 1'b1;
        wait_ack(n);
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        check({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
        check({tag, "_grant"}, 32'(grant_idx), idx);
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        req[idx] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        logic [23:0] exp_ovf_bcd;
        logic        ack_seen;
        int          n;

        sys_rst = 1'b1;
        req     = '0;
        data    = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_ack", 32'(ack), 0);
        check("rst_bcd", 32'(bcd_out), 0);
        check("rst_grant", 32'(grant_idx), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(ovf), 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // Single request from idle, index 0 wins first after reset.
        set_data(0, 20'd123456);
        req[0] = 1'b1;
        serve("single", 0, 24'h123456, 1'b0, 22);
        repeat (3) @(posedge sys_clk);
        #1;
        check("hold_bcd", 32'(bcd_out), 32'h123456);
        check("hold_busy", 32'(busy), 0);

        // Boundaries: zero and the largest in-range value.
        set_data(1, 20'd0);
        req[1] = 1'b1;
        serve("zero", 1, 24'h000000, 1'b0, 22);
        set_data(2, 20'd999999);
        req[2] = 1'b1;
        serve("max", 2, 24'h999999, 1'b0, 23);

        // Fairness: last grant was 2, so 0 goes before 2.
        set_data(0, 20'd42);
        set_data(2, 20'd7);
        req = 4'b0101;
        serve("fair0", 0, 24'h000042, 1'b0, 23);
        serve("fair2", 2, 24'h000007, 1'b0, 23);

        // Contention from a fresh reset: order 0,1,2,3 at 22,45,68,91.
        pulse_reset();
        set_data(0, 20'd314159);
        set_data(1, 20'd271828);
        set_data(2, 20'd161803);
        set_data(3, 20'd141421);
        req = 4'b1111;
        serve("cont0", 0, 24'h314159, 1'b0, 22);
        serve("cont1", 1, 24'h271828, 1'b0, 23);
        serve("cont2", 2, 24'h161803, 1'b0, 23);
        serve("cont3", 3, 24'h141421, 1'b0, 23);

        // Overflow: 1048575 is above the six-digit range.
`ifdef BCD_ARB_OVF_CLAMP_EN
        exp_ovf_bcd = 24'h999999;
`else
        exp_ovf_bcd = 24'h048575;
`endif
        set_data(3, 20'd1048575);
        req[3] = 1'b1;
        serve("ovf", 3, exp_ovf_bcd, 1'b1, 23);
        repeat (2) @(posedge sys_clk);
        #1;
        check("ovf_hold", 32'(ovf), 1);

        // Reset in cycle 10 of a conversion aborts it without an ack.
        @(negedge sys_clk);
        set_data(1, 20'd55555);
        req[1] = 1'b1;
        ack_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge sys_clk);
            #1;
            if (ack != '0) ack_seen = 1'b1;
        end
        check("mid_busy", 32'(busy), 1);
        sys_rst = 1'b1;
        #1;
        check("mid_noack", 32'(ack_seen), 0);
        check("mid_rst_ack", 32'(ack), 0);
        check("mid_rst_bcd", 32'(bcd_out), 0);
        check("mid_rst_grant", 32'(grant_idx), 0);
        check("mid_rst_ovf", 32'(ovf), 0);
        check("mid_rst_busy", 32'(busy), 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        serve("rearb", 1, 24'h055555, 1'b0, 22);

        // No stray acks once all requests are gone.
        ack_seen = 1'b0;
        n = 0;
        repeat (30) begin
            @(posedge sys_clk);
            #1;
            if (ack != '0) ack_seen = 1'b1;
            n++;
        end
        check("idle_noack", 32'(ack_seen), 0);
        check("idle_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_arbiter.md
BCD_ARBITER -- requirements
Module: bcd_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (legal range 2..8).
REQ-002 The block SHALL have port sys_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req, input, N_REQ bits: per-requester conversion request, level.
REQ-005 The block SHALL have port data, input, N_REQ*20 bits: requester i value in slice [20i+19:20i], range 0..999999.
REQ-006 The block SHALL have port ack, output, N_REQ bits: one-cycle pulse to the served requester when its result is valid.
REQ-007 The block SHALL have port bcd_out, output, 24 bits: six BCD digits, [3:0] units up to [23:20] hundred-thousands.
REQ-008 The block SHALL have port grant_idx, output, clog2(N_REQ) bits: index of the requester currently or last served.
REQ-009 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 The block SHALL have port ovf, output, 1 bit: the served value exceeded 999999; valid with ack.

Function
REQ-011 The FSM SHALL have states IDLE, LOAD, SHIFT and DONE.
REQ-012 IDLE SHALL sample req every cycle; if any bit is set, the FSM latches the winner index and its data, then goes to LOAD.
REQ-013 Arbitration SHALL be round-robin: search starts at (last grant + 1) mod N_REQ; after reset, last grant = N_REQ-1, so index 0 wins first.
REQ-014 LOAD (1 cycle) SHALL clear the 24-bit digit register and load the 20-bit shift register.
REQ-015 SHIFT SHALL last exactly 20 cycles; each cycle adds 3 to every digit greater than 4, then shifts the combined register left by 1.
REQ-016 A 5-bit counter SHALL track SHIFT cycles (0..19) and leave SHIFT at count 19.
REQ-017 DONE (1 cycle) SHALL assert ack[grant_idx] and update bcd_out and ovf in the same cycle, then return to IDLE.
REQ-018 Latency SHALL be fixed: req sampled in IDLE at cycle 0 gives ack high in cycle 22.
REQ-019 bcd_out, grant_idx and ovf SHALL hold their values until the next DONE.
REQ-020 Requesters SHALL hold req and data stable until ack, and SHALL deassert req on the edge that ends the ack cycle.
REQ-021 req changes outside IDLE SHALL be ignored; latched data SHALL NOT change mid-conversion.
REQ-022 When several requests are pending simultaneously, they SHALL be served one per 23-cycle slot in round-robin order; no requester waits more than N_REQ slots.
REQ-023 The block SHALL be throughput-only: one conversion at a time, no queueing beyond the req lines.

Reset
REQ-024 Asserting sys_rst at any time, including mid-SHIFT, SHALL immediately force IDLE, counter 0, last grant N_REQ-1, and set ack, bcd_out, grant_idx, ovf and busy to 0.
REQ-025 An aborted conversion SHALL NOT produce an ack; the requester re-arbitrates after reset release.

Configuration
REQ-026 With macro BCD_ARB_OVF_CLAMP_EN defined, a latched value above 999999 SHALL be replaced by 999999 before LOAD and ovf SHALL be set.
REQ-027 Without BCD_ARB_OVF_CLAMP_EN, the value SHALL be converted unmodified, bcd_out SHALL equal the value mod 1000000, and ovf SHALL still flag the overflow.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the constant SHIFT_CYCLES = 20, BCD_DIGITS = 6 and MAX_VAL = 999999.
REQ-029 The shift/add-3 datapath SHALL be a sub-module bcd_dabble_core (load, shift_en, 20-bit in, 24-bit out), with sequencing and arbitration in bcd_arbiter.

Verification
REQ-030 Single request: req[0]=1, data0=123456 -> ack[0] in cycle 22, bcd_out=0x123456, grant_idx=0, ovf=0.
REQ-031 Contention: req=4'b1111 with distinct values -> acks in order 0,1,2,3 at cycles 22,45,68,91, each with the correct BCD value.
REQ-032 Fairness: after serving index 2, req=4'b0101 -> index 0 is served before 2.
REQ-033 Boundaries: data 0 -> 0x000000; data 999999 -> 0x999999.
REQ-034 Overflow: data 1048575 -> ovf=1; bcd_out=0x999999 with BCD_ARB_OVF_CLAMP_EN, 0x048575 without it.
REQ-035 Reset mid-conversion: sys_rst asserted at cycle 10 -> outputs 0 and no ack; after release the same requester receives ack 22 cycles after re-sampling.
